// File: rtl/mips_main_2_pkg.sv
// mips_pkg: shared constants for the single-cycle MIPS subset core.
//   - 6-bit opcode constants for the supported instruction formats
//   - 6-bit R-type function-field constants
//   - 3-bit ALU operation enum shared by the control path and mips_alu
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

endpackage

// File: rtl/mips_main_2_if.sv
// mips_main_2_if: operand/result bundle between the core control path and the ALU.
//   a, b   : 32-bit operands        (driven by master)
//   op     : ALU operation          (driven by master)
//   y      : 32-bit result          (driven by slave)
//   zero   : y == 0                 (driven by slave)
interface mips_main_2_if;
  import mips_pkg::*;

  logic [31:0] a;
  logic [31:0] b;
  alu_op_e     op;
  logic [31:0] y;
  logic        zero;

  modport master (output a, b, op, input  y, zero);
  modport slave  (input  a, b, op, output y, zero);
endinterface

// File: rtl/mips_main_2_alu.sv
// mips_alu: purely combinational 32-bit ALU for the MIPS subset.
//   alu.a, alu.b, alu.op : operands and operation (input)
//   alu.y                : result, 32-bit wrap-around, slt is signed
//   alu.zero             : result equals zero (used for beq)
module mips_alu
  import mips_pkg::*;
(
  mips_main_2_if.slave alu
);

  always_comb begin
    alu.y = 32'h0;
    case (alu.op)
      ALU_ADD: alu.y = alu.a + alu.b;
      ALU_SUB: alu.y = alu.a - alu.b;
      ALU_AND: alu.y = alu.a & alu.b;
      ALU_OR:  alu.y = alu.a | alu.b;
      ALU_SLT: alu.y = {31'h0, $signed(alu.a) < $signed(alu.b)};
      default: alu.y = 32'h0;
    endcase
  end

  assign alu.zero = (alu.y == 32'h0);

endmodule

// File: rtl/mips_main_2.sv
// mips_main_2: single-cycle 32-bit MIPS subset processor (PC, instruction ROM,
// 32x32 register file, ALU, data RAM). One instruction retires per clock.
//   clock : rising-edge clock for all state
//   reset : synchronous active-high; clears pc and rf, leaves dmem intact
// State is observed hierarchically: pc, rf[0:31], dmem[], imem[].
// Optional build macro MIPS_TRACE_EN: prints a per-instruction trace line plus
// register-file and memory write lines. Undefined: no trace code at all.
module mips_main_2
  import mips_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.mem"
) (
  input logic clock,
  input logic reset
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];
  logic [31:0] pc;

  // Memory images exist from time 0; dmem is never cleared by reset.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0;
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = 32'h0;
  end

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val, pc_plus4, next_pc, wr_data;
  logic [4:0]  wr_reg;
  logic        rf_we, dm_we, wb_mem;
  logic [DA-1:0] dm_idx;

  // Upper PC bits are ignored so fetch wraps inside the ROM.
  assign instr    = imem[pc[IA+1:2]];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf[rt];
  assign pc_plus4 = pc + 32'd4;

  mips_main_2_if alu_bus ();
  mips_alu u_alu (.alu(alu_bus.slave));

  assign alu_bus.a = rs_val;
  assign dm_idx    = alu_bus.y[DA+1:2];
  assign wr_data   = wb_mem ? dmem[dm_idx] : alu_bus.y;

  // Decode: anything not listed leaves both write enables low (NOP).
  always_comb begin
    rf_we       = 1'b0;
    dm_we       = 1'b0;
    wb_mem      = 1'b0;
    wr_reg      = rt;
    alu_bus.b   = imm_sext;
    alu_bus.op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        wr_reg    = rd;
        alu_bus.b = rt_val;
        rf_we     = 1'b1;
        case (funct)
          F_ADD:   alu_bus.op = ALU_ADD;
          F_SUB:   alu_bus.op = ALU_SUB;
          F_AND:   alu_bus.op = ALU_AND;
          F_OR:    alu_bus.op = ALU_OR;
          F_SLT:   alu_bus.op = ALU_SLT;
          default: rf_we      = 1'b0;
        endcase
      end
      OP_ADDI: rf_we = 1'b1;
      OP_LW: begin
        rf_we  = 1'b1;
        wb_mem = 1'b1;
      end
      OP_SW:  dm_we = 1'b1;
      OP_BEQ: begin
        alu_bus.b  = rt_val;
        alu_bus.op = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Next-PC kept apart from decode so the ALU zero flag never feeds back
  // into the block that drives the ALU operands.
  always_comb begin
    next_pc = pc_plus4;
    if (opcode == OP_BEQ && alu_bus.zero)
      next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
    else if (opcode == OP_J)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (rf_we && wr_reg != 5'd0) rf[wr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && dm_we) dmem[dm_idx] <= rt_val;
  end

`ifdef MIPS_TRACE_EN
  always @(posedge clock) begin
    if (!reset) begin
      $display("pc=%h instr=%h", pc, instr);
      if (rf_we && wr_reg != 5'd0) $display("r%0d<=%h", wr_reg, wr_data);
      if (dm_we) $display("m[%h]<=%h", alu_bus.y, rt_val);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mips_main_2.sv
module tb_mips_main_2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mips_main_2 #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .IMEM_FILE("")) dut (
    .clock(clk),
    .reset(rst)
  );

  // Architectural reference model: ISA-level interpreter over plain arrays.
  logic [31:0] prog [64];
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_wr(input int r, input logic [31:0] v);
    if (r != 0) m_rf[r] = v;
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, se, npc, addr;
    int op, rs, rt, rd, fn;
    ins  = prog[(m_pc / 4) % 64];
    op   = int'(ins[31:26]);
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    fn   = int'(ins[5:0]);
    a    = m_rf[rs];
    b    = m_rf[rt];
    se   = 32'($signed(ins[15:0]));
    addr = a + se;
    npc  = m_pc + 4;
    case (op)
      0: case (fn)
        'h20: m_wr(rd, a + b);
        'h22: m_wr(rd, a - b);
        'h24: m_wr(rd, a & b);
        'h25: m_wr(rd, a | b);
        'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      'h08: m_wr(rt, addr);
      'h23: m_wr(rt, m_dm[(addr / 4) % 64]);
      'h2B: m_dm[(addr / 4) % 64] = b;
      'h04: if (a == b) npc = m_pc + 4 + se * 4;
      'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, dut.pc, m_pc);
    for (int r = 0; r < 32; r++) check($sformatf("%s_r%0d", tag, r), dut.rf[r], m_rf[r]);
  endtask

  // One clock edge with the given reset level, model advanced in step.
  task automatic cycle(input logic r, input string tag);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    if (r) model_reset(); else model_step();
    #1;
    check_state(tag);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) m_dm[i] = 0;
    model_reset();

    // Reset and NOP stream: pc climbs by 4 from zero.
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    #1 load_prog();
    cycle(1'b1, "rst0");
    cycle(1'b1, "rst1");
    check("rst_pc", dut.pc, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, "nop");
      check($sformatf("nop_pc%0d", k), dut.pc, 32'(4 * k));
    end

    // Directed program covering arithmetic, memory, branches, jump, illegal op.
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0]  = itype('h08, 0, 1, 5);
    prog[1]  = itype('h08, 0, 2, -3);
    prog[2]  = rtype(1, 2, 3, 'h20);
    prog[3]  = rtype(1, 2, 4, 'h22);
    prog[4]  = rtype(2, 1, 5, 'h2A);
    prog[5]  = itype('h2B, 0, 1, 8);
    prog[6]  = itype('h23, 0, 6, 8);
    prog[7]  = itype('h23, 0, 7, 'h0B);
    prog[8]  = itype('h08, 0, 0, 7);
    prog[9]  = itype('h04, 1, 1, 2);
    prog[10] = itype('h08, 0, 8, 1);
    prog[11] = itype('h08, 0, 8, 2);
    prog[12] = itype('h04, 1, 2, 5);
    prog[13] = 32'hFC00_0000;
    prog[14] = itype('h08, 0, 10, 'h0F0);
    prog[15] = itype('h08, 0, 11, 'h0FF);
    prog[16] = rtype(10, 11, 12, 'h24);
    prog[17] = rtype(10, 11, 13, 'h25);
    prog[18] = 32'h0800_0000;
    load_prog();
    cycle(1'b1, "drst");
    for (int k = 1; k <= 17; k++) begin
      cycle(1'b0, "dir");
      if (k == 10) check("beq_taken_pc", dut.pc, 32'd48);
      if (k == 11) check("beq_not_pc", dut.pc, 32'd52);
      if (k == 12) check("illegal_pc", dut.pc, 32'd56);
    end
    check("add", dut.rf[3], 32'd2);
    check("sub", dut.rf[4], 32'd8);
    check("slt", dut.rf[5], 32'd1);
    check("lw8", dut.rf[6], 32'd5);
    check("lw0b", dut.rf[7], 32'd5);
    check("sw_mem", dut.dmem[2], 32'd5);
    check("r0_zero", dut.rf[0], 32'd0);
    check("skipped", dut.rf[8], 32'd0);
    check("and", dut.rf[12], 32'h0F0);
    check("or", dut.rf[13], 32'h0FF);
    check("j0_pc", dut.pc, 32'd0);

    // Reset mid-program: registers clear, data memory survives.
    for (int k = 0; k < 3; k++) cycle(1'b0, "pre");
    cycle(1'b1, "midrst");
    check("mid_pc", dut.pc, 32'd0);
    check("mid_r1", dut.rf[1], 32'd0);
    check("mid_r13", dut.rf[13], 32'd0);
    check("mid_dmem", dut.dmem[2], 32'd5);

    // Random programs against the interpreter, with sporadic resets.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) begin
        int kind, s, t, d;
        kind = int'($urandom_range(0, 11));
        s = int'($urandom_range(0, 7));
        t = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 7));
        case (kind)
          0: prog[i] = rtype(s, t, d, 'h20);
          1: prog[i] = rtype(s, t, d, 'h22);
          2: prog[i] = rtype(s, t, d, 'h24);
          3: prog[i] = rtype(s, t, d, 'h25);
          4: prog[i] = rtype(s, t, d, 'h2A);
          5, 6: prog[i] = itype('h08, s, t, int'($urandom_range(0, 65535)));
          7: prog[i] = itype('h23, s, t, int'($urandom_range(0, 1023)));
          8: prog[i] = itype('h2B, s, t, int'($urandom_range(0, 1023)));
          9: prog[i] = itype('h04, s, t, int'($urandom_range(0, 6)) - 3);
          10: prog[i] = {6'h02, 26'($urandom_range(0, 63))};
          default: prog[i] = ($urandom_range(0, 1) != 0) ? 32'hFC00_1234 : rtype(s, t, d, 'h21);
        endcase
      end
      load_prog();
      cycle(1'b1, "rrst");
      for (int c = 0; c < 300; c++)
        cycle(($urandom_range(0, 99) == 0), "rnd");
      for (int i = 0; i < 64; i++) check($sformatf("dmem%0d", i), dut.dmem[i], m_dm[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
